// File: rtl/imc_tile_engine.sv
// imc_tile_engine: row-masked tile MAC engine with zero skipping, IMC/digital modes and per-tile statistics
module imc_tile_engine #(
  parameter int NUM_ROWS = 64,
  parameter int DIG_LAT = 4,
  parameter int E_IMC_OP = 3,
  parameter int E_SKIP = 1,
  parameter int SNR_BASE = 120,
  parameter int SNR_SHIFT = 1,
  parameter int SNR_SIM_PENALTY = 20,
  parameter int SNR_DIGITAL = 255,
  localparam int RW = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tile_start,
  input  logic                imc_mode,
  input  logic                simultaneous_rows,
  input  logic [NUM_ROWS-1:0] row_mask,
  input  logic                op_valid,
  input  logic [7:0]          op_a,
  input  logic [7:0]          op_b,
  output logic                op_ready,
  output logic [RW-1:0]       op_row_idx,
  output logic                busy,
  output logic                tile_done,
  output logic [15:0]         zero_ops_skipped,
  output logic [15:0]         total_ops_executed,
  output logic [15:0]         imc_energy_savings,
  output logic [7:0]          computation_snr,
  output logic [31:0]         acc_result
);
  typedef enum logic [1:0] {IDLE, RUN, DIG_WAIT, FINISH} state_t;
  state_t state;
  logic [NUM_ROWS-1:0] mask_l;
  logic imc_l, sim_l;
  logic [15:0] skip_cnt, exec_cnt, prod, wait_cnt, hs_prod, exec_prod;
  logic [31:0] acc;
  logic hs, zero, last_row, adv, do_skip, do_exec;
  logic [23:0] energy;
  int snr_i;
  logic [7:0] snr;
  always_comb begin
    op_ready = state == RUN && mask_l[op_row_idx];
    busy = state != IDLE;
    hs = op_ready && op_valid;
    zero = op_a == 8'd0 || op_b == 8'd0;
    hs_prod = 16'(op_a) * 16'(op_b);
    last_row = op_row_idx == RW'(NUM_ROWS - 1);
    do_skip = hs && zero;
    do_exec = (hs && !zero && (imc_l || DIG_LAT == 1)) || (state == DIG_WAIT && wait_cnt == 16'(DIG_LAT - 2));
    adv = (state == RUN && !mask_l[op_row_idx]) || do_skip || do_exec;
    exec_prod = state == DIG_WAIT ? prod : hs_prod;
    energy = (imc_l ? 24'(exec_cnt) * 24'(E_IMC_OP) : 24'd0) + 24'(skip_cnt) * 24'(E_SKIP);
    snr_i = imc_l ? SNR_BASE - int'(exec_cnt >> SNR_SHIFT) - (sim_l ? SNR_SIM_PENALTY : 0) : SNR_DIGITAL;
    snr = snr_i < 0 ? 8'd0 : snr_i > 255 ? 8'd255 : 8'(snr_i);
  end
  always_ff @(posedge clk) begin
    tile_done <= 1'b0;
    if (rst) begin
      state <= IDLE;
      op_row_idx <= '0;
      mask_l <= '0;
      imc_l <= 1'b0;
      sim_l <= 1'b0;
      skip_cnt <= '0;
      exec_cnt <= '0;
      prod <= '0;
      wait_cnt <= '0;
      acc <= '0;
      zero_ops_skipped <= '0;
      total_ops_executed <= '0;
      imc_energy_savings <= '0;
      computation_snr <= '0;
      acc_result <= '0;
    end else begin
      case (state)
        IDLE: if (tile_start) begin
          mask_l <= row_mask;
          imc_l <= imc_mode;
          sim_l <= simultaneous_rows;
          skip_cnt <= '0;
          exec_cnt <= '0;
          acc <= '0;
          op_row_idx <= '0;
          state <= RUN;
        end
        RUN, DIG_WAIT: begin
          if (do_skip) skip_cnt <= skip_cnt + 16'd1;
          if (do_exec) begin
            exec_cnt <= exec_cnt + 16'd1;
            acc <= acc + 32'(exec_prod);
          end
          if (adv) begin
            state <= last_row ? FINISH : RUN;
            op_row_idx <= last_row ? op_row_idx : op_row_idx + RW'(1);
          end else if (hs) begin
            prod <= hs_prod;
            wait_cnt <= '0;
            state <= DIG_WAIT;
          end else if (state == DIG_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        FINISH: begin
          zero_ops_skipped <= skip_cnt;
          total_ops_executed <= exec_cnt;
          acc_result <= acc;
          imc_energy_savings <= |energy[23:16] ? 16'hFFFF : energy[15:0];
          computation_snr <= snr;
          tile_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
